rom_lane_viewer: RTL and testbench
==================================

// Module: rom_lane_viewer
// PURPOSE
//  Parametrised ROM inspection front-end for board-level memory bring-up. Drives the
//  address of a synchronous ROM (1-cycle read latency) from switches (manual mode) or an
//  internal auto-scan counter (scan mode). Debounces lane pushbuttons and latches a
//  sticky lane selection. Shows the selected LANE_W-bit slice of the captured word on LEDs.
//  Sits between board pins and the memory instance in bring-up tops.
// PARAMETERS
//  ADDR_W     8      ROM address width; switch width
//  DATA_W     32     ROM word width; must be a multiple of LANE_W
//  LANE_W     8      display slice width; LED count
//  DEB_CYCLES 16     cycles a raw button level must be stable to be accepted (>=2)
//  SCAN_DIV   1024   clocks per address step in scan mode (>=2)
//  localparam NLANES = DATA_W/LANE_W; LSEL_W = clog2(NLANES), min 1
// PORTS
//  clk        in   1        system clock, all logic on rising edge
//  resetn     in   1        asynchronous active-low reset
//  sw         in   ADDR_W   manual address (asynchronous pins; double-flop internally)
//  btn        in   NLANES   raw lane buttons, active high, btn[i] selects lane i
//  scan_en    in   1        1 = auto-scan mode, 0 = manual mode (double-flopped)
//  mem_addr   out  ADDR_W   ROM address, registered
//  mem_rdata  in   DATA_W   ROM read data, valid 1 clk after mem_addr changes
//  leds       out  LANE_W   selected lane of captured word, registered
//  lane_sel   out  LSEL_W   current lane index
//  lane_vld   out  1        1 once any lane has been selected since reset
//  wrap       out  1        1-clk pulse when scan counter wraps max->0
// BEHAVIOUR
//  Reset: mem_addr=0, leds=0, lane_sel=0, lane_vld=0, wrap=0; debounce counters,
//   scan divider and synchronisers cleared; captured word=0.
//  Sync: sw, btn, scan_en each pass two flops before use (2-clk input latency).
//  Debounce: per button, counter reloads on any change of synced level vs stable level.
//   After DEB_CYCLES equal samples, the stable level updates. Press event = stable 0->1.
//  Lane select: on a cycle with exactly one press event and no other stable-high button,
//   lane_sel<=index, lane_vld<=1. Simultaneous/overlapping presses: ignored, selection kept.
//   Release does not clear selection (sticky).
//  Manual mode: mem_addr<=synced sw every clk; scan divider held at 0.
//  Scan mode: divider counts 0..SCAN_DIV-1. On terminal count, mem_addr<=mem_addr+1 mod
//   2^ADDR_W. Wrap from all-ones to 0 asserts wrap for that single clk.
//  Mode change: scan->manual: next clk loads sw. Manual->scan: scan starts from the
//   current mem_addr, divider from 0.
//  Read pipeline: word_q<=mem_rdata every clk. leds<=lane_vld ? word_q[lane_sel*LANE_W
//   +:LANE_W] : 0. Address-to-LED latency is 2 clks (ROM + word_q) plus 1 (leds reg) = 3 clks.
//  Lane change visible on leds 1 clk after lane_sel updates.
//  Reset mid-operation: all state returns to reset values immediately. Selection is lost.
//   First post-reset LED update follows the normal latency.
// TESTING
//  1 ROM[0x05]=0xDEADBEEF, manual, sw=0x05, press btn[2] -> leds=0xAD, lane_sel=2, lane_vld=1.
//  2 Bounce btn[1] with a 3-clk toggle train, DEB_CYCLES=16 -> no selection change;
//    btn[1] held 16+2 clks -> lane_sel=1.
//  3 btn[0] and btn[3] pressed in the same clk -> lane_sel, lane_vld and leds unchanged.
//  4 scan_en=1, SCAN_DIV=4, start addr 0xFE -> mem_addr 0xFF then 0x00 every 4 clks;
//    wrap high exactly 1 clk at 0x00.
//  5 sw step 0x10->0x11 -> leds reflects ROM[0x11] exactly 3 clks after mem_addr changes
//    (plus 2-clk sync).
//  6 resetn low mid-scan at addr 0x42 -> all outputs 0 asynchronously; after release,
//    manual sw=0x42 restarts cleanly, leds=0 until a lane is pressed.

Source files
------------

// File: rtl/rom_lane_viewer.sv
// rom_lane_viewer: drives a synchronous ROM address from switches or an auto-scan
// counter and shows a debounced, sticky-selected lane of the read word on LEDs.
// Ports: clk/resetn, sw (manual addr), btn (lane buttons), scan_en (mode),
//        mem_addr/mem_rdata (ROM side), leds, lane_sel, lane_vld, wrap (scan wrap pulse).
module rom_lane_viewer #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int LANE_W     = 8,
  parameter int DEB_CYCLES = 16,
  parameter int SCAN_DIV   = 1024,
  localparam int NLANES    = DATA_W / LANE_W,
  localparam int LSEL_W    = (NLANES > 1) ? $clog2(NLANES) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] sw,
  input  logic [NLANES-1:0] btn,
  input  logic              scan_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [LANE_W-1:0] leds,
  output logic [LSEL_W-1:0] lane_sel,
  output logic              lane_vld,
  output logic              wrap
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [ADDR_W-1:0] sw_s1, sw_s2;
  logic [NLANES-1:0] btn_s1, btn_s2;
  logic              scan_s1, scan_s2;

  logic [NLANES-1:0] btn_stb;
  logic [NLANES-1:0] btn_stb_q;
  logic [CNT_W-1:0]  deb_cnt [NLANES];

  logic [DIV_W-1:0]  div;
  logic [DATA_W-1:0] word_q;

  logic [NLANES-1:0] press;
  logic [LSEL_W-1:0] press_idx;
  logic              press_ok;
  logic [LANE_W-1:0] lane_word;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      btn_s1  <= '0;
      btn_s2  <= '0;
      scan_s1 <= 1'b0;
      scan_s2 <= 1'b0;
    end else begin
      sw_s1   <= sw;
      sw_s2   <= sw_s1;
      btn_s1  <= btn;
      btn_s2  <= btn_s1;
      scan_s1 <= scan_en;
      scan_s2 <= scan_s1;
    end
  end

  // Counter tracks consecutive samples that differ from the stable level;
  // any sample agreeing with the stable level restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_stb   <= '0;
      btn_stb_q <= '0;
      for (int i = 0; i < NLANES; i++) deb_cnt[i] <= '0;
    end else begin
      btn_stb_q <= btn_stb;
      for (int i = 0; i < NLANES; i++) begin
        if (btn_s2[i] == btn_stb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
          deb_cnt[i] <= '0;
          btn_stb[i] <= btn_s2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    press     = btn_stb & ~btn_stb_q;
    press_idx = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (press[i]) press_idx = LSEL_W'(i);
    end
  end

  // Accept only a lone press with no other button currently held.
  assign press_ok = (press != '0)
                 && ((press & (press - NLANES'(1))) == '0)
                 && ((btn_stb & ~press) == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane_sel <= '0;
      lane_vld <= 1'b0;
    end else if (press_ok) begin
      lane_sel <= press_idx;
      lane_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr <= '0;
      div      <= '0;
      wrap     <= 1'b0;
    end else if (!scan_s2) begin
      mem_addr <= sw_s2;
      div      <= '0;
      wrap     <= 1'b0;
    end else if (div == DIV_W'(SCAN_DIV - 1)) begin
      div      <= '0;
      mem_addr <= mem_addr + ADDR_W'(1);
      wrap     <= &mem_addr;
    end else begin
      div      <= div + DIV_W'(1);
      wrap     <= 1'b0;
    end
  end

  always_comb begin
    lane_word = '0;
    for (int i = 0; i < NLANES; i++) begin
      if (lane_sel == LSEL_W'(i)) lane_word = word_q[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      word_q <= '0;
      leds   <= '0;
    end else begin
      word_q <= mem_rdata;
      leds   <= lane_vld ? lane_word : '0;
    end
  end

endmodule

// File: tb/tb_rom_lane_viewer.sv
// tb_rom_lane_viewer: directed bench for rom_lane_viewer with a
// behavioural 1-cycle ROM; each task checks one scenario inline.
module tb_rom_lane_viewer;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int LANE_W = 8;
  localparam int NL     = 4;
  localparam int LS_W   = 2;

  logic              clk;
  logic              resetn;
  logic [ADDR_W-1:0] sw;
  logic [NL-1:0]     btn;
  logic              scan_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [LANE_W-1:0] leds;
  logic [LS_W-1:0]   lane_sel;
  logic              lane_vld;
  logic              wrap;

  int checks;
  int errors;

  rom_lane_viewer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANE_W(LANE_W),
    .DEB_CYCLES(16), .SCAN_DIV(4)
  ) dut (
    .clk(clk), .resetn(resetn), .sw(sw), .btn(btn),
    .scan_en(scan_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .leds(leds),
    .lane_sel(lane_sel), .lane_vld(lane_vld), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: lane3=a^A0, lane2=a, lane1=~a, lane0=a^3C; 0x05 holds DEADBEEF
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    if (a == 8'h05) return 32'hDEADBEEF;
    return {a ^ 8'hA0, a, ~a, a ^ 8'h3C};
  endfunction

  always @(posedge clk) mem_rdata <= rom_word(mem_addr);

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    resetn = 1'b0; sw = '0; btn = '0; scan_en = 1'b0;
    clks(3);
    checks++;
    if (mem_addr !== 8'h00) begin errors++;
      $display("FAIL reset_addr got %h want 00", mem_addr); end
    checks++;
    if (leds !== 8'h00) begin errors++;
      $display("FAIL reset_leds got %h want 00", leds); end
    checks++;
    if ({lane_vld, lane_sel, wrap} !== 4'b0) begin errors++;
      $display("FAIL reset_flags got %b want 0000",
               {lane_vld, lane_sel, wrap}); end
    resetn = 1'b1;
    clks(2);
  endtask

  task automatic test_select;
    sw = 8'h05;
    clks(6);
    checks++;
    if (mem_addr !== 8'h05) begin errors++;
      $display("FAIL manual_addr got %h want 05", mem_addr); end
    checks++;
    if (leds !== 8'h00) begin errors++;
      $display("FAIL leds_before_sel got %h want 00", leds); end
    btn = 4'b0100;
    for (int k = 0; k < 60 && lane_vld !== 1'b1; k++) clks(1);
    clks(3);
    checks++;
    if (lane_vld !== 1'b1 || lane_sel !== 2'd2) begin errors++;
      $display("FAIL select_lane2 got vld=%b sel=%0d want vld=1 sel=2",
               lane_vld, lane_sel); end
    checks++;
    if (leds !== 8'hAD) begin errors++;
      $display("FAIL select_leds got %h want AD", leds); end
    btn = '0;
    clks(25);
  endtask

  task automatic test_bounce;
    for (int r = 0; r < 5; r++) begin
      btn = 4'b0010; clks(3);
      btn = 4'b0000; clks(3);
    end
    clks(25);
    checks++;
    if (lane_sel !== 2'd2 || lane_vld !== 1'b1) begin errors++;
      $display("FAIL bounce_ignored got sel=%0d vld=%b want sel=2 vld=1",
               lane_sel, lane_vld); end
    btn = 4'b0010;
    clks(18);
    btn = '0;
    clks(4);
    checks++;
    if (lane_sel !== 2'd1) begin errors++;
      $display("FAIL held_lane1 got %0d want 1", lane_sel); end
    checks++;
    if (leds !== 8'hBE) begin errors++;
      $display("FAIL held_leds got %h want BE", leds); end
    clks(25);
  endtask

  task automatic test_overlap;
    btn = 4'b1001;
    clks(25);
    checks++;
    if (lane_sel !== 2'd1 || lane_vld !== 1'b1) begin errors++;
      $display("FAIL overlap_sel got sel=%0d vld=%b want sel=1 vld=1",
               lane_sel, lane_vld); end
    checks++;
    if (leds !== 8'hBE) begin errors++;
      $display("FAIL overlap_leds got %h want BE", leds); end
    btn = '0;
    clks(25);
    checks++;
    if (lane_sel !== 2'd1) begin errors++;
      $display("FAIL overlap_release got %0d want 1", lane_sel); end
  endtask

  task automatic test_scan;
    int cyc, t_ff, t_00, nwrap;
    logic wrap0;
    logic [7:0] prev, a;
    sw = 8'hFE;
    clks(5);
    checks++;
    if (mem_addr !== 8'hFE) begin errors++;
      $display("FAIL scan_start got %h want FE", mem_addr); end
    scan_en = 1'b1;
    cyc = 0; t_ff = -100; t_00 = -100; nwrap = 0; wrap0 = 1'b0;
    prev = mem_addr;
    for (int k = 0; k < 40; k++) begin
      clks(1);
      cyc++;
      a = mem_addr;
      if (a != prev && a == 8'hFF) t_ff = cyc;
      if (a != prev && a == 8'h00) t_00 = cyc;
      if (wrap === 1'b1) begin
        nwrap++;
        if (a == 8'h00 && a != prev) wrap0 = 1'b1;
      end
      prev = a;
    end
    checks++;
    if (t_00 - t_ff !== 4) begin errors++;
      $display("FAIL scan_step got %0d want 4 (ff@%0d 00@%0d)",
               t_00 - t_ff, t_ff, t_00); end
    checks++;
    if (nwrap !== 1 || wrap0 !== 1'b1) begin errors++;
      $display("FAIL scan_wrap got n=%0d at0=%b want n=1 at0=1",
               nwrap, wrap0); end
    scan_en = 1'b0;
    sw = 8'h10;
    clks(6);
    checks++;
    if (mem_addr !== 8'h10) begin errors++;
      $display("FAIL scan_to_manual got %h want 10", mem_addr); end
  endtask

  task automatic test_latency;
    clks(4);
    checks++;
    if (leds !== 8'hEF) begin errors++;
      $display("FAIL lat_base got %h want EF", leds); end
    sw = 8'h11;
    clks(2);
    checks++;
    if (mem_addr !== 8'h10) begin errors++;
      $display("FAIL lat_sync got %h want 10", mem_addr); end
    clks(1);
    checks++;
    if (mem_addr !== 8'h11) begin errors++;
      $display("FAIL lat_addr got %h want 11", mem_addr); end
    clks(2);
    checks++;
    if (leds !== 8'hEF) begin errors++;
      $display("FAIL lat_early got %h want EF", leds); end
    clks(1);
    checks++;
    if (leds !== 8'hEE) begin errors++;
      $display("FAIL lat_leds got %h want EE", leds); end
  endtask

  task automatic test_reset_mid;
    sw = 8'h42;
    clks(5);
    scan_en = 1'b1;
    clks(3);
    checks++;
    if (mem_addr !== 8'h42 || leds !== 8'hBD) begin errors++;
      $display("FAIL pre_reset got addr=%h leds=%h want 42 BD",
               mem_addr, leds); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (mem_addr !== 8'h00 || leds !== 8'h00) begin errors++;
      $display("FAIL async_reset got addr=%h leds=%h want 00 00",
               mem_addr, leds); end
    checks++;
    if ({lane_vld, lane_sel, wrap} !== 4'b0) begin errors++;
      $display("FAIL async_flags got %b want 0000",
               {lane_vld, lane_sel, wrap}); end
    scan_en = 1'b0;
    clks(2);
    resetn = 1'b1;
    clks(8);
    checks++;
    if (mem_addr !== 8'h42 || lane_vld !== 1'b0 || leds !== 8'h00)
    begin errors++;
      $display("FAIL post_reset got addr=%h vld=%b leds=%h want 42 0 00",
               mem_addr, lane_vld, leds); end
    btn = 4'b1000;
    for (int k = 0; k < 60 && lane_vld !== 1'b1; k++) clks(1);
    clks(3);
    checks++;
    if (lane_sel !== 2'd3 || leds !== 8'hE2) begin errors++;
      $display("FAIL post_reset_sel got sel=%0d leds=%h want 3 E2",
               lane_sel, leds); end
    btn = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_select();
    test_bounce();
    test_overlap();
    test_scan();
    test_latency();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
